// File: rtl/lifo_stack_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : lifo_stack_pkg                                             |
// | Brief   : Shared defaults and command-priority encoding for the LIFO.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package lifo_stack_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;

  // Decoded command, already resolved by priority (flush > replace > push > pop)
  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_PUSH  = 3'd1,
    CMD_POP   = 3'd2,
    CMD_REPL  = 3'd3,
    CMD_FLUSH = 3'd4
  } cmd_t;

  function automatic cmd_t decode_cmd(input logic push, input logic pop,
                                      input logic flush, input logic empty);
    if (flush)            return CMD_FLUSH;
    else if (push && pop) return empty ? CMD_PUSH : CMD_REPL;
    else if (push)        return CMD_PUSH;
    else if (pop)         return CMD_POP;
    else                  return CMD_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lifo_stack_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : lifo_stack_if                                              |
// | Brief   : Control/data bundle for lifo_stack; peek signals exist     |
// |           only when LIFO_STACK_PEEK_EN is defined.                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface lifo_stack_if
  import lifo_stack_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
);
  logic                  push;
  logic                  pop;
  logic                  flush;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic [CNT_WIDTH-1:0]  count;
  logic                  empty;
  logic                  full;
  logic                  ovf;
  logic                  unf;
`ifdef LIFO_STACK_PEEK_EN
  logic [CNT_WIDTH-1:0]  peek_idx;
  logic [DATA_WIDTH-1:0] peek_data;

  modport master (output push, pop, flush, clr_err, data_in, peek_idx,
                  input  data_out, count, empty, full, ovf, unf, peek_data);
  modport slave  (input  push, pop, flush, clr_err, data_in, peek_idx,
                  output data_out, count, empty, full, ovf, unf, peek_data);
`else
  modport master (output push, pop, flush, clr_err, data_in,
                  input  data_out, count, empty, full, ovf, unf);
  modport slave  (input  push, pop, flush, clr_err, data_in,
                  output data_out, count, empty, full, ovf, unf);
`endif
endinterface
`default_nettype wire

// File: rtl/lifo_stack_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : lifo_stack_ptr                                             |
// | Brief   : Stack pointer, command decode, occupancy flags and sticky  |
// |           error flags; drives the storage write port.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lifo_stack_ptr
  import lifo_stack_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1),
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic [CNT_WIDTH-1:0]  sp,
  output logic                  empty,
  output logic                  full,
  output logic                  ovf,
  output logic                  unf,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr
);

  localparam logic [CNT_WIDTH-1:0] C_FULL_SP = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] C_ONE     = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] r_sp;
  logic                 r_empty;
  logic                 r_full;
  logic                 r_ovf;
  logic                 r_unf;

  cmd_t                 w_cmd;
  logic [CNT_WIDTH-1:0] w_sp_next;
  logic                 w_set_ovf;
  logic                 w_set_unf;
  logic                 w_wr_en;
  logic [ADDR_WIDTH-1:0] w_wr_addr;

  assign w_cmd = decode_cmd(push, pop, flush, r_empty);

  always_comb begin
    w_sp_next = r_sp;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    w_wr_en   = 1'b0;
    w_wr_addr = ADDR_WIDTH'(r_sp);
    case (w_cmd)
      CMD_FLUSH: w_sp_next = '0;
      CMD_REPL: begin
        w_wr_en   = 1'b1;
        w_wr_addr = ADDR_WIDTH'(r_sp - C_ONE);
      end
      CMD_PUSH: begin
        if (r_full) begin
          w_set_ovf = 1'b1;
        end else begin
          w_wr_en   = 1'b1;
          w_sp_next = r_sp + C_ONE;
        end
      end
      CMD_POP: begin
        if (r_empty) w_set_unf = 1'b1;
        else         w_sp_next = r_sp - C_ONE;
      end
      default: ;
    endcase
  end

  // Occupancy flags are registered from the next pointer so they never glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp    <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_sp    <= w_sp_next;
      r_empty <= (w_sp_next == '0);
      r_full  <= (w_sp_next == C_FULL_SP);
      r_ovf   <= (r_ovf & ~clr_err) | w_set_ovf;
      r_unf   <= (r_unf & ~clr_err) | w_set_unf;
    end
  end

  assign sp      = r_sp;
  assign empty   = r_empty;
  assign full    = r_full;
  assign ovf     = r_ovf;
  assign unf     = r_unf;
  assign wr_en   = w_wr_en;
  assign wr_addr = w_wr_addr;

endmodule
`default_nettype wire

// File: rtl/lifo_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : lifo_stack                                                 |
// | Brief   : Parametrised LIFO with replace-top, flush, count and error |
// |           flags. Define LIFO_STACK_PEEK_EN for the indexed peek port.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lifo_stack
  import lifo_stack_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  lifo_stack_if.slave bus
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [CNT_WIDTH-1:0]  w_sp;
  logic                  w_empty;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [ADDR_WIDTH-1:0] w_rd_addr;

  lifo_stack_ptr #(
    .DEPTH      (DEPTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (bus.push),
    .pop     (bus.pop),
    .flush   (bus.flush),
    .clr_err (bus.clr_err),
    .sp      (w_sp),
    .empty   (w_empty),
    .full    (bus.full),
    .ovf     (bus.ovf),
    .unf     (bus.unf),
    .wr_en   (w_wr_en),
    .wr_addr (w_wr_addr)
  );

  // Storage is intentionally unreset; the empty gate hides stale entries
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= bus.data_in;
  end

  assign w_rd_addr    = ADDR_WIDTH'(w_sp - CNT_WIDTH'(1));
  assign bus.data_out = w_empty ? '0 : r_mem[w_rd_addr];
  assign bus.count    = w_sp;
  assign bus.empty    = w_empty;

`ifdef LIFO_STACK_PEEK_EN
  logic [ADDR_WIDTH-1:0] w_peek_addr;

  assign w_peek_addr   = ADDR_WIDTH'(w_sp - CNT_WIDTH'(1) - bus.peek_idx);
  assign bus.peek_data = (bus.peek_idx < w_sp) ? r_mem[w_peek_addr] : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lifo_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_lifo_stack                                              |
// | Brief   : Self-checking bench: vector table, corner sequences and    |
// |           random traffic against a queue-based reference model.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_lifo_stack;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  lifo_stack_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) bus ();

  lifo_stack #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain queue, top at the back
  logic [DW-1:0] m_q[$];
  logic          m_ovf;
  logic          m_unf;

  typedef struct {
    logic          p;
    logic          po;
    logic          f;
    logic          c;
    logic [DW-1:0] d;
    logic [DW-1:0] eo;
    int            ec;
    logic          eovf;
    logic          eunf;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic p, input logic po, input logic f,
                            input logic c, input logic [DW-1:0] d);
    logic so;
    logic su;
    so = 1'b0;
    su = 1'b0;
    if (f) m_q.delete();
    else if (p && po) begin
      if (m_q.size() == 0) m_q.push_back(d);
      else m_q[m_q.size()-1] = d;
    end else if (p) begin
      if (m_q.size() == DEPTH) so = 1'b1;
      else m_q.push_back(d);
    end else if (po) begin
      if (m_q.size() == 0) su = 1'b1;
      else void'(m_q.pop_back());
    end
    m_ovf = (m_ovf && !c) || so;
    m_unf = (m_unf && !c) || su;
  endtask

  task automatic check_model(input string tag);
    int exp_out;
    exp_out = (m_q.size() == 0) ? 0 : int'(m_q[m_q.size()-1]);
    check({tag, ".data_out"}, int'(bus.data_out), exp_out);
    check({tag, ".count"},    int'(bus.count),    m_q.size());
    check({tag, ".empty"},    int'(bus.empty),    int'(m_q.size() == 0));
    check({tag, ".full"},     int'(bus.full),     int'(m_q.size() == DEPTH));
    check({tag, ".ovf"},      int'(bus.ovf),      int'(m_ovf));
    check({tag, ".unf"},      int'(bus.unf),      int'(m_unf));
  endtask

  // Called at a falling edge; returns at the next falling edge with the model updated
  task automatic do_cycle(input logic p, input logic po, input logic f,
                          input logic c, input logic [DW-1:0] d);
    bus.push    = p;
    bus.pop     = po;
    bus.flush   = f;
    bus.clr_err = c;
    bus.data_in = d;
    @(posedge clk);
    @(negedge clk);
    model_step(p, po, f, c, d);
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.flush   = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    rst_n = 1'b0;
    bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;
    bus.data_in = '0;
`ifdef LIFO_STACK_PEEK_EN
    bus.peek_idx = '0;
`endif

    //          p  po f  c  din    out    cnt ovf unf
    vecs[0]  = '{1, 0, 0, 0, 8'h11, 8'h11, 1, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 8'h22, 8'h22, 2, 0, 0};
    vecs[2]  = '{1, 0, 0, 0, 8'h33, 8'h33, 3, 0, 0};
    vecs[3]  = '{0, 1, 0, 0, 8'h00, 8'h22, 2, 0, 0};
    vecs[4]  = '{0, 1, 0, 0, 8'h00, 8'h11, 1, 0, 0};
    vecs[5]  = '{1, 0, 0, 0, 8'h22, 8'h22, 2, 0, 0};
    vecs[6]  = '{1, 1, 0, 0, 8'h99, 8'h99, 2, 0, 0};
    vecs[7]  = '{0, 1, 0, 0, 8'h00, 8'h11, 1, 0, 0};
    vecs[8]  = '{0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0};
    vecs[9]  = '{0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 1};
    vecs[10] = '{0, 1, 0, 1, 8'h00, 8'h00, 0, 0, 1};
    vecs[11] = '{0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0};
    vecs[12] = '{1, 1, 0, 0, 8'h5A, 8'h5A, 1, 0, 0};
    vecs[13] = '{1, 0, 0, 0, 8'h01, 8'h01, 2, 0, 0};
    vecs[14] = '{1, 0, 0, 0, 8'h02, 8'h02, 3, 0, 0};
    vecs[15] = '{1, 0, 0, 0, 8'h03, 8'h03, 4, 0, 0};
    vecs[16] = '{1, 0, 0, 0, 8'h04, 8'h04, 5, 0, 0};
    vecs[17] = '{1, 0, 1, 0, 8'h77, 8'h00, 0, 0, 0};
    vecs[18] = '{0, 1, 1, 0, 8'h00, 8'h00, 0, 0, 0};

    repeat (2) @(negedge clk);
    check("reset.data_out", int'(bus.data_out), 0);
    check("reset.count",    int'(bus.count),    0);
    check("reset.empty",    int'(bus.empty),    1);
    check("reset.full",     int'(bus.full),     0);
    check("reset.ovf",      int'(bus.ovf),      0);
    check("reset.unf",      int'(bus.unf),      0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      do_cycle(vecs[i].p, vecs[i].po, vecs[i].f, vecs[i].c, vecs[i].d);
      check($sformatf("vec%0d.data_out", i), int'(bus.data_out), int'(vecs[i].eo));
      check($sformatf("vec%0d.count", i),    int'(bus.count),    vecs[i].ec);
      check($sformatf("vec%0d.empty", i),    int'(bus.empty),    int'(vecs[i].ec == 0));
      check($sformatf("vec%0d.ovf", i),      int'(bus.ovf),      int'(vecs[i].eovf));
      check($sformatf("vec%0d.unf", i),      int'(bus.unf),      int'(vecs[i].eunf));
    end

    // Fill to full, overflow, clear
    for (int i = 0; i < DEPTH; i++) do_cycle(1, 0, 0, 0, DW'(i));
    check("fill.full",  int'(bus.full),  1);
    check("fill.count", int'(bus.count), DEPTH);
    do_cycle(1, 0, 0, 0, 8'hAA);
    check("ovf.count",    int'(bus.count),    DEPTH);
    check("ovf.data_out", int'(bus.data_out), 8'h0F);
    check("ovf.flag",     int'(bus.ovf),      1);
    do_cycle(0, 0, 0, 1, 8'h00);
    check("clr.ovf", int'(bus.ovf), 0);
    do_cycle(1, 0, 0, 1, 8'hAB);
    check("clr_and_ovf.ovf", int'(bus.ovf), 1);
    check_model("full_seq");

    // Asynchronous reset between edges with COUNT=4, OVF=1
    for (int i = 0; i < DEPTH - 4; i++) do_cycle(0, 1, 0, 0, 8'h00);
    check("pre_rst.count", int'(bus.count), 4);
    check("pre_rst.ovf",   int'(bus.ovf),   1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.count",    int'(bus.count),    0);
    check("async_rst.ovf",      int'(bus.ovf),      0);
    check("async_rst.data_out", int'(bus.data_out), 0);
    check("async_rst.empty",    int'(bus.empty),    1);
    m_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_model("post_rst");

`ifdef LIFO_STACK_PEEK_EN
    do_cycle(1, 0, 0, 0, 8'd1);
    do_cycle(1, 0, 0, 0, 8'd2);
    do_cycle(1, 0, 0, 0, 8'd3);
    bus.peek_idx = CW'(2);
    #1;
    check("peek2", int'(bus.peek_data), 1);
    bus.peek_idx = CW'(3);
    #1;
    check("peek3", int'(bus.peek_data), 0);
    bus.peek_idx = CW'(0);
    #1;
    check("peek0", int'(bus.peek_data), 3);
    @(negedge clk);
`endif

    // Random traffic: push-heavy then pop-heavy phases to reach both ends
    for (int n = 0; n < 600; n++) begin
      int r;
      logic p, po, f, c;
      r  = $urandom_range(0, 99);
      p  = (n % 200 < 100) ? (r < 70) : (r < 25);
      po = (n % 200 < 100) ? ($urandom_range(0, 99) < 25) : ($urandom_range(0, 99) < 70);
      f  = ($urandom_range(0, 63) == 0);
      c  = ($urandom_range(0, 7) == 0);
      do_cycle(p, po, f, c, DW'($urandom));
      check_model($sformatf("rnd%0d", n));
`ifdef LIFO_STACK_PEEK_EN
      begin
        int idx;
        int exp_pk;
        idx = $urandom_range(0, DEPTH);
        bus.peek_idx = CW'(idx);
        #1;
        exp_pk = (idx < m_q.size()) ? int'(m_q[m_q.size()-1-idx]) : 0;
        check($sformatf("rnd%0d.peek", n), int'(bus.peek_data), exp_pk);
        @(negedge clk);
        check_model($sformatf("rnd%0d.idle", n));
      end
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
Parametrised hardware LIFO that succeeds the fixed 8-bit single-control stack used for CALL/RET and PUSH/POP in the microprocessor datapath.
- Separate PUSH/POP strobes replace the combined CE/nRW control.
- Adds replace-top, synchronous flush, occupancy count, and sticky overflow/underflow error flags.
- Sits between the stack-input mux (ACC or PC+1) and the ALU-mux/PC-load paths.

Parameters:
DATA_WIDTH, 8, width of each stack entry
DEPTH, 16, number of entries (must be ≥2)
CNT_WIDTH, $clog2(DEPTH+1), width of occupancy count and stack pointer

Ports:
CLK  input  1  clock, rising-edge active
nRST  input  1  reset, active-low
PUSH  input  1  push request for this cycle
POP  input  1  pop request for this cycle
FLUSH  input  1  synchronous empty request
CLR_ERR  input  1  clears the sticky OVF/UNF flags
DATA_IN  input  DATA_WIDTH  data pushed or written
DATA_OUT  output  DATA_WIDTH  current top entry, 0 when empty
COUNT  output  CNT_WIDTH  number of valid entries
EMPTY  output  1  COUNT==0
FULL  output  1  COUNT==DEPTH
OVF  output  1  sticky flag: push attempted while full
UNF  output  1  sticky flag: pop attempted while empty

Behaviour:
- Clocking and reset: one clock, CLK. Reset nRST is asynchronous and active-low.
- Reset values: SP=0, COUNT=0, EMPTY=1, FULL=0, OVF=0, UNF=0, DATA_OUT=0. Entry storage is not reset; stale contents are never visible because DATA_OUT is gated by EMPTY.
- Stack pointer: SP is the next free slot (0..DEPTH). DATA_OUT is mem[SP-1], combinational from registers, so there is zero read latency. A push is visible on DATA_OUT the cycle after the edge.
- Command priority, evaluated at each rising edge:
  1. FLUSH: SP<=0. PUSH/POP are ignored in that cycle, and no error is raised.
  2. PUSH & POP, not empty: replace top. mem[SP-1]<=DATA_IN; SP is unchanged; no error.
  3. PUSH & POP, empty: treated as a plain push. mem[0]<=DATA_IN, SP<=1; UNF is not set.
  4. PUSH only, not full: mem[SP]<=DATA_IN, SP<=SP+1.
  5. PUSH only, full: storage and SP are unchanged; OVF<=1.
  6. POP only, not empty: SP<=SP-1. The popped value is the DATA_OUT shown before the edge.
  7. POP only, empty: SP is unchanged; UNF<=1.
- Error flags: CLR_ERR clears OVF/UNF at the edge. If a new error occurs in the same cycle, the set wins and the flag stays 1.
- Wrap-around: none. SP saturates at 0 and DEPTH. Memory addresses never wrap.
- Reset mid-operation: asserting nRST empties the stack immediately, without waiting for CLK. Pending requests are dropped.
- COUNT, EMPTY and FULL are derived from SP, are registered-state based, and are glitch-free.

Optional Feature:
- Macro: LIFO_STACK_PEEK_EN.
- Defined: adds input PEEK_IDX[CNT_WIDTH-1:0] and output PEEK_DATA[DATA_WIDTH-1:0].
  - PEEK_DATA = mem[SP-1-PEEK_IDX] when PEEK_IDX < COUNT, else 0.
  - Combinational read; there is no state effect.
- Undefined: neither port exists, and storage is inferred with a single read port.

Decomposition:
- Shared package/header lifo_defs: command-priority encoding constants (CMD_NONE, CMD_PUSH, CMD_POP, CMD_REPL, CMD_FLUSH) and the default DATA_WIDTH/DEPTH.
- One sub-module, lifo_ptr: owns SP, COUNT, EMPTY/FULL, the command decode and the OVF/UNF flags. It outputs the write enable and write address to the storage array kept in lifo_stack.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 → DATA_OUT=0x33, COUNT=3. Pop twice → DATA_OUT=0x11, COUNT=1, EMPTY=0.
- With DEPTH=16, push 0x00..0x0F → FULL=1. A 17th push of 0xAA → COUNT=16, DATA_OUT=0x0F, OVF=1. CLR_ERR → OVF=0.
- Pop on empty → UNF=1, COUNT=0, DATA_OUT=0. Same-cycle CLR_ERR with pop on empty → UNF remains 1.
- COUNT=2, top=0x22, then PUSH&POP with DATA_IN=0x99 → COUNT=2, DATA_OUT=0x99. Pop → DATA_OUT=0x11. PUSH&POP on empty with 0x5A → COUNT=1, DATA_OUT=0x5A, UNF=0.
- COUNT=5, then FLUSH asserted together with PUSH 0x77 → COUNT=0, EMPTY=1, DATA_OUT=0, no flags set.
- Assert nRST low mid-cycle between edges while COUNT=4 and OVF=1 → immediately COUNT=0, OVF=0, DATA_OUT=0. With LIFO_STACK_PEEK_EN defined: after pushes 1,2,3, PEEK_IDX=2 → PEEK_DATA=1; PEEK_IDX=3 → PEEK_DATA=0.
